// File: rtl/result_serializer.sv
// result_serializer: captures an alignment result and streams it as OUT_W-bit beats closed by an XOR checksum beat
module result_serializer #(
    parameter int SCORE_W = 16,
    parameter int POS_W   = 8,
    parameter int OUT_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               res_done,
    input  logic [SCORE_W-1:0] res_score,
    input  logic [POS_W-1:0]   res_row,
    input  logic [POS_W-1:0]   res_col,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic               out_last,
    output logic               busy,
    output logic               overrun
);
    localparam int FRAME_W = SCORE_W + 2 * POS_W;
    localparam int NB      = FRAME_W / OUT_W;
    localparam int CNT_W   = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [1:0] {IDLE, SEND, CSUM} state_t;

    state_t             state, state_nx;
    logic [FRAME_W-1:0] shreg;
    logic [OUT_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;
    logic               last_data;

    assign last_data = cnt == CNT_W'(NB - 1);

    // state register; reset discards any frame in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // next state and outputs, all decoded from registers only
    always_comb begin
        state_nx  = state;
        out_valid = state != IDLE;
        out_last  = state == CSUM;
        busy      = state != IDLE;
        out_data  = state == SEND ? shreg[OUT_W-1:0] : state == CSUM ? acc : '0;
        state_nx  = (state == IDLE && res_done)               ? SEND :
                    (state == SEND && out_ready && last_data) ? CSUM :
                    (state == CSUM && out_ready)              ? IDLE : state;
    end

    // capture on accepted result, shift and fold each transferred data beat into the checksum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            acc     <= '0;
            cnt     <= '0;
            overrun <= 1'b0;
        end else begin
            overrun <= res_done && state != IDLE;
            if (state == IDLE && res_done) begin
                shreg <= {res_col, res_row, res_score};
                acc   <= '0;
                cnt   <= '0;
            end else if (state == SEND && out_ready) begin
                shreg <= shreg >> OUT_W;
                acc   <= acc ^ shreg[OUT_W-1:0];
                cnt   <= cnt + 1'b1;
            end
        end
    end
endmodule
